// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential RV32M multiplier.
// Also holds the operand magnitude helper used when an op is accepted.
package mul_pkg;

   localparam int XLEN      = 32;
   localparam int MUL_STEPS = 32;
   localparam logic [4:0] LAST_STEP = 5'(MUL_STEPS - 1);

   typedef enum logic [1:0] {
      MUL    = 2'b00,
      MULH   = 2'b01,
      MULHSU = 2'b10,
      MULHU  = 2'b11
   } mul_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } mul_state_e;

   // 0x80000000 maps to itself, read back as an unsigned magnitude
   function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] x, input logic is_signed);
      logic [XLEN-1:0] m;
      if (is_signed && x[XLEN-1]) begin
         m = ~x + 32'd1;
      end else begin
         m = x;
      end
      return m;
   endfunction

endpackage

// File: rtl/add_32.sv
// 32-bit ripple-carry adder built from a chain of full adders.
module add_32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] s,
   output logic        cout
);

   // Carry ripples from bit 0 upward, one full adder per bit
   always_comb begin
      logic [32:0] c_v;
      c_v    = 33'd0;
      c_v[0] = cin;
      s      = 32'd0;
      for (int i = 0; i < 32; i++) begin
         s[i]     = a[i] ^ b[i] ^ c_v[i];
         c_v[i+1] = (a[i] & b[i]) | (a[i] & c_v[i]) | (b[i] & c_v[i]);
      end
      cout = c_v[32];
   end

endmodule

// File: rtl/mul_seq_32.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Multiplies magnitudes for 32 cycles, then fixes the sign in one extra cycle.
module mul_seq_32
   import mul_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   mul_state_e      state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] a_mag_q, a_mag_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic            neg_q, neg_d;
   mul_op_e         op_q, op_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            out_valid_q, out_valid_d;
   logic            in_ready_q, in_ready_d;
   logic            busy_q, busy_d;

   logic [XLEN-1:0] acc_b_s, acc_sum_s;
   logic            acc_c_s;
   logic [XLEN-1:0] neg_lo_s, neg_hi_s;
   logic            neg_lo_c_s, neg_hi_c_s;
   logic            a_signed_s, b_signed_s, use_neg_s;
   logic [XLEN-1:0] prod_lo_s, prod_hi_s;

   assign acc_b_s = lo_q[0] ? a_mag_q : 32'd0;

   add_32 u_acc (
      .a    (hi_q),
      .b    (acc_b_s),
      .cin  (1'b0),
      .s    (acc_sum_s),
      .cout (acc_c_s)
   );

   add_32 u_neg_lo (
      .a    (~lo_q),
      .b    (32'd0),
      .cin  (1'b1),
      .s    (neg_lo_s),
      .cout (neg_lo_c_s)
   );

   add_32 u_neg_hi (
      .a    (~hi_q),
      .b    (32'd0),
      .cin  (neg_lo_c_s),
      .s    (neg_hi_s),
      .cout (neg_hi_c_s)
   );

   // Carry out of the full negation means the magnitude was zero, already the answer
   assign use_neg_s  = neg_q & ~neg_hi_c_s;
   assign prod_lo_s  = use_neg_s ? neg_lo_s : lo_q;
   assign prod_hi_s  = use_neg_s ? neg_hi_s : hi_q;
   assign a_signed_s = (op == 2'b01) || (op == 2'b10);
   assign b_signed_s = (op == 2'b01);

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_mag_d  = a_mag_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      neg_d    = neg_q;
      op_d     = op_q;
      result_d = result_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_mag_d = mag32(a, a_signed_s);
               lo_d    = mag32(b, b_signed_s);
               hi_d    = 32'd0;
               neg_d   = (a_signed_s & a[XLEN-1]) ^ (b_signed_s & b[XLEN-1]);
               op_d    = mul_op_e'(op);
               cnt_d   = 5'd0;
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            hi_d  = {acc_c_s, acc_sum_s[XLEN-1:1]};
            lo_d  = {acc_sum_s[0], lo_q[XLEN-1:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_STEP) begin
               state_d = FIX;
            end else begin
               state_d = CALC;
            end
         end
         FIX: begin
            if (!flush) begin
               result_d = (op_q == MUL) ? prod_lo_s : prod_hi_s;
            end else begin
               result_d = result_q;
            end
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (flush) begin
         state_d = IDLE;
      end else begin
         state_d = state_d;
      end

      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
      out_valid_d = (state_d == DONE);
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 5'd0;
         a_mag_q     <= 32'd0;
         hi_q        <= 32'd0;
         lo_q        <= 32'd0;
         neg_q       <= 1'b0;
         op_q        <= MUL;
         result_q    <= 32'd0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_mag_q     <= a_mag_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         neg_q       <= neg_d;
         op_q        <= op_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign busy      = busy_q;

endmodule
